// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Bridges CPU load/store requests (valid/ready) to a word-addressed data RAM
//   with combinational read and posedge write. Byte/half stores are performed
//   as read-modify-write; loads are sign- or zero-extended; misaligned and
//   out-of-range requests return resp_err without touching the RAM.
//
// Parameters
//   MEM_WORDS     RAM depth in words; addr[31:2] >= MEM_WORDS is out of range
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   req_*         request handshake: valid/ready, we, size, unsigned, addr, wdata
//   resp_*        one-cycle response: valid, rdata (0 for stores/errors), err
//   mem_*         RAM side: read/write strobes, aligned address, write data,
//                 combinational read data
//
// Optional build macro
//   LSU_PERF_EN   adds perf_loads / perf_stores / perf_errs event counters
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef LSU_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_errs
`endif
);

    typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, ERR, RESP} state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [15:0] wdata_q;     // only the low half is ever merged into a word
`ifdef LSU_PERF_EN
    logic        we_q;
`endif

    logic        misaligned;
    logic        out_of_range;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    assign misaligned   = (req_size == 2'b11)
                       || (req_size == 2'b01 && req_addr[0])
                       || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;

    // Half-word lanes fall out of the same byte shift because addr[0] is 0.
    assign shamt   = {lane_q, 3'b000};
    assign shifted = mem_rdata >> shamt;

    always_comb begin
        ld_ext    = mem_rdata;
        lane_mask = '1;
        case (size_q)
            2'b00: begin
                ld_ext    = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                ld_ext    = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        merged = (mem_rdata & ~lane_mask) | (({16'h0000, wdata_q} << shamt) & lane_mask);
    end

    assign resp_valid = (state == RESP);
    assign mem_read   = (state == LD) || (state == RMW_RD);
    assign mem_write  = (state == WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
`ifdef LSU_PERF_EN
            we_q        <= 1'b0;
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        resp_err  <= 1'b0;
                        lane_q    <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
`ifdef LSU_PERF_EN
                        we_q      <= req_we;
`endif
                        if (misaligned || out_of_range) begin
                            state <= ERR;
                        end else if (!req_we) begin
                            state <= LD;
                        end else if (req_size == 2'b10) begin
                            mem_wdata <= req_wdata;
                            state     <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LD: begin
                    resp_rdata <= ld_ext;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_wdata <= merged;
                    state     <= WR;
                end
                WR: begin
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                ERR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef LSU_PERF_EN
                    if (resp_err)  perf_errs   <= perf_errs + 32'd1;
                    else if (we_q) perf_stores <= perf_stores + 32'd1;
                    else           perf_loads  <= perf_loads + 32'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned NWORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
    int unsigned m_loads = 0, m_stores = 0, m_errs = 0;
`endif

    load_store_unit #(.MEM_WORDS(NWORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
`endif
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT, and the bench's own picture of what it should hold
    logic [31:0] ram    [NWORDS];
    logic [31:0] shadow [NWORDS];
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expectation for the request currently in flight
    bit          cur_active = 0;
    bit          cur_err, cur_we;
    logic [1:0]  cur_size;
    logic [31:0] cur_maddr, cur_wword, cur_rdata;
    int          cur_due;
    logic [31:0] last_rdata;
    logic        last_err;
    bit          run_cmp = 0;

    always @(negedge clk) begin
        if (run_cmp && rst_n) begin
            chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (mem_write) begin
                chk("write_legal", {31'b0, cur_active & ~cur_err & cur_we}, 32'd1);
                chk("write_addr", mem_addr, cur_maddr);
                chk("write_data", mem_wdata, cur_wword);
            end
            if (mem_read) begin
                chk("read_legal", {31'b0, cur_active & ~cur_err & ~(cur_we & (cur_size == 2'b10))}, 32'd1);
                chk("read_addr", mem_addr, cur_maddr);
            end
            if (cur_active && cyc == cur_due) begin
                chk("resp_valid", {31'b0, resp_valid}, 32'd1);
                chk("resp_rdata", resp_rdata, cur_rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, cur_err});
                last_rdata = resp_rdata;
                last_err   = resp_err;
                cur_active = 0;
            end else begin
                chk("resp_idle", {31'b0, resp_valid}, 32'd0);
            end
        end
    end

    // Model: compute the response and the RAM word the request must produce.
    task automatic start_req(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        int nbytes, bits, lat;
        longint unsigned v, mask;
        logic [31:0] w;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!req_ready) begin
            chk("ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        nbytes   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        cur_err  = (size == 2'b11) || (addr % nbytes != 0) || ((addr / 4) >= NWORDS);
        cur_we   = we;
        cur_size = size;
        cur_maddr = addr & 32'hFFFF_FFFC;
        cur_rdata = '0;
        cur_wword = '0;
        if (!cur_err) begin
            w = shadow[(addr / 4) % NWORDS];
            if (!we) begin
                bits = 8 * nbytes;
                v = longint'(w) >> (8 * (addr % 4));
                if (bits < 32) begin
                    mask = (64'd1 << bits) - 1;
                    v = v & mask;
                    if (!uns && v[bits-1]) v = v | ~mask;
                end
                cur_rdata = v[31:0];
            end else begin
                for (int i = 0; i < nbytes; i++)
                    w[8*((addr % 4) + i) +: 8] = wd[8*i +: 8];
                cur_wword = w;
            end
        end
        lat = (cur_err || !we || size == 2'b10) ? 2 : 3;
        cur_due    = cyc + lat;
        cur_active = 1;
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk); #1;
        req_valid = 0;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n = 0;
        start_req(we, size, uns, addr, wd);
        while (cur_active && n < 10) begin @(negedge clk); #1; n++; end
        if (cur_active) begin
            chk("resp_timeout", 32'd0, 32'd1);
            cur_active = 0;
        end
        if (we && !cur_err) shadow[(addr / 4) % NWORDS] = cur_wword;
`ifdef LSU_PERF_EN
        if (cur_err) m_errs++; else if (we) m_stores++; else m_loads++;
`endif
        rd = last_rdata;
        er = last_err;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < NWORDS; i++) begin ram[i] = '0; shadow[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_outs", {26'b0, resp_valid, resp_err, mem_read, mem_write, 2'b0}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
        run_cmp = 1;

        // Word store, then word load
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er);
        chk("pin_ram_word", ram[4], 32'hDEADBEEF);
        chk("pin_store_rdata", rd, 32'd0);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, rd, er);
        chk("pin_word_load", rd, 32'hDEADBEEF);

        // Byte store RMW and byte loads
        do_req(1, 2'b00, 0, 32'h11, 32'h0000007F, rd, er);
        chk("pin_rmw_byte", ram[4], 32'hDEAD7FEF);
        do_req(0, 2'b00, 0, 32'h13, 32'h0, rd, er);
        chk("pin_byte_signed", rd, 32'hFFFFFFDE);
        do_req(0, 2'b00, 1, 32'h13, 32'h0, rd, er);
        chk("pin_byte_unsigned", rd, 32'h000000DE);

        // Half store to upper lane, half loads
        do_req(1, 2'b01, 0, 32'h12, 32'hFFFF8001, rd, er);
        chk("pin_rmw_half", ram[4], 32'h80017FEF);
        do_req(0, 2'b01, 0, 32'h12, 32'h0, rd, er);
        chk("pin_half_signed", rd, 32'hFFFF8001);
        do_req(0, 2'b01, 1, 32'h10, 32'h0, rd, er);
        chk("pin_half_unsigned", rd, 32'h00007FEF);

        // Byte store with junk upper bits only touches its lane
        do_req(1, 2'b10, 0, 32'h20, 32'h11223344, rd, er);
        do_req(1, 2'b00, 0, 32'h20, 32'hFFFFFFAB, rd, er);
        chk("pin_lane0", ram[8], 32'h112233AB);

        // Errors: misaligned, size 11, out of range; in-range boundary
        do_req(0, 2'b01, 0, 32'h11, 32'h0, rd, er);
        chk("pin_mis_half_err", {31'b0, er}, 32'd1);
        chk("pin_mis_half_rdata", rd, 32'd0);
        do_req(0, 2'b10, 0, 32'h12, 32'h0, rd, er);
        do_req(0, 2'b11, 0, 32'h10, 32'h0, rd, er);
        do_req(1, 2'b10, 0, 32'h400, 32'hCAFEF00D, rd, er);
        chk("pin_oor_err", {31'b0, er}, 32'd1);
        do_req(1, 2'b10, 0, 32'h3FC, 32'h01020304, rd, er);
        chk("pin_last_word", ram[255], 32'h01020304);
        do_req(0, 2'b00, 0, 32'h3FF, 32'h0, rd, er);
        chk("pin_last_byte", rd, 32'h00000001);
        chk("pin_err_ram", ram[4], 32'h80017FEF);

        // Reset during RMW_RD of a byte store
        start_req(1, 2'b00, 0, 32'h21, 32'h00000055);
        chk("abort_in_rmw_rd", {31'b0, mem_read}, 32'd1);
        #2 rst_n = 0;
        cur_active = 0;
`ifdef LSU_PERF_EN
        m_loads = 0; m_stores = 0; m_errs = 0;
`endif
        #1;
        chk("abort_state", {28'b0, mem_read, mem_write, resp_valid, req_ready}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_write", {30'b0, mem_write, resp_valid}, 32'd0);
        end
        #2 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("abort_ram", ram[8], 32'h112233AB);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);

        // Functional again after reset
        do_req(0, 2'b00, 1, 32'h21, 32'h0, rd, er);
        chk("pin_post_abort", rd, 32'h00000033);
        do_req(1, 2'b00, 0, 32'h33, 32'h00000099, rd, er);
        do_req(0, 2'b01, 0, 32'h11, 32'h0, rd, er);
        @(negedge clk);

`ifdef LSU_PERF_EN
        chk("perf_loads", perf_loads, m_loads);
        chk("perf_stores", perf_stores, m_stores);
        chk("perf_errs", perf_errs, m_errs);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
